// File: rtl/agc_controller.sv
// agc_controller -- closed-loop automatic gain control for the receiver front end.
//
// The controller averages 2^AVG_LOG2 RSSI samples, compares the average with
// TARGET_DB, and moves the front-end gain toward the target. It steps at most
// STEP_MAX dB per decision and holds still inside a +/-HYST_DB dead band.
// Each new gain goes to the AFE over a set / in-progress handshake. The
// controller then discards SETTLE_SAMPLES valid samples so that the next
// average only covers data taken at the new gain.
//
// Ports:
//   clk, rst_n              core clock, async active-low reset
//   en_i                    loop enable (level); low forces IDLE next cycle
//   rssi_dB_i / _valid_i    averaged RSSI, unsigned Q8.8 dB, one-cycle strobe
//   gain_set_in_progress_i  AFE busy applying the last commanded gain
//   gain_dB_o               commanded gain, dB (held while disabled)
//   set_gain_o              one-cycle apply strobe, gain_dB_o already stable
//   datapath_en_o           high in every state except IDLE
//   locked_o                last average fell inside the dead band
//   at_limit_o              last decision was clamped at GAIN_MIN/GAIN_MAX
//   timeout_o               sticky: an AFE handshake phase timed out
module agc_controller #(
  parameter logic [15:0] TARGET_DB      = 16'h3C00,
  parameter logic [15:0] HYST_DB        = 16'h0300,
  parameter logic [7:0]  GAIN_INIT      = 8'd30,
  parameter logic [7:0]  GAIN_MIN       = 8'd0,
  parameter logic [7:0]  GAIN_MAX       = 8'd60,
  parameter logic [7:0]  STEP_MAX       = 8'd12,
  parameter int          AVG_LOG2       = 4,
  parameter int          SETTLE_SAMPLES = 32,
  parameter int          ACK_TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [15:0] rssi_dB_i,
  input  logic        rssi_dB_valid_i,
  input  logic        gain_set_in_progress_i,
  output logic [7:0]  gain_dB_o,
  output logic        set_gain_o,
  output logic        datapath_en_o,
  output logic        locked_o,
  output logic        at_limit_o,
  output logic        timeout_o
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int NAVG  = 1 << AVG_LOG2;
  localparam int CNT_W = $clog2((SETTLE_SAMPLES > NAVG) ? SETTLE_SAMPLES : NAVG) + 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE, APPLY, WAIT_HI, WAIT_LO, SETTLE, MEASURE, DECIDE
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] timer;

  // Decision datapath: evaluated continuously, only consumed in DECIDE.
  logic [15:0]        avg;
  logic signed [16:0] err;
  logic [16:0]        err_abs;
  logic               in_band;
  logic signed [16:0] delta;
  logic signed [9:0]  gain_sum;
  logic [7:0]         new_gain;
  logic               clamped;

  always_comb begin
    avg     = 16'(acc >> AVG_LOG2);
    err     = $signed({1'b0, TARGET_DB}) - $signed({1'b0, avg});
    err_abs = err[16] ? 17'(-err) : 17'(err);
    in_band = (err_abs <= {1'b0, HYST_DB});

    // Whole-dB step. Any error outside the dead band moves at least 1 dB.
    delta = err >>> 8;
    if (delta == 17'sd0)
      delta = err[16] ? -17'sd1 : 17'sd1;
    if (delta > $signed({9'd0, STEP_MAX}))
      delta = $signed({9'd0, STEP_MAX});
    else if (delta < -$signed({9'd0, STEP_MAX}))
      delta = -$signed({9'd0, STEP_MAX});

    // delta is within +/-STEP_MAX, so 10 signed bits hold gain + delta.
    gain_sum = $signed({2'b00, gain_dB_o}) + $signed(delta[9:0]);
    clamped  = 1'b0;
    new_gain = gain_sum[7:0];
    if (gain_sum < $signed({2'b00, GAIN_MIN})) begin
      new_gain = GAIN_MIN;
      clamped  = 1'b1;
    end else if (gain_sum > $signed({2'b00, GAIN_MAX})) begin
      new_gain = GAIN_MAX;
      clamped  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      gain_dB_o     <= GAIN_INIT;
      set_gain_o    <= 1'b0;
      datapath_en_o <= 1'b0;
      locked_o      <= 1'b0;
      at_limit_o    <= 1'b0;
      timeout_o     <= 1'b0;
      acc           <= '0;
      cnt           <= '0;
      timer         <= '0;
    end else begin
      set_gain_o <= 1'b0;
      if (!en_i) begin
        // Abandon whatever was in flight. The gain holds; counters restart.
        state         <= IDLE;
        datapath_en_o <= 1'b0;
        acc           <= '0;
        cnt           <= '0;
        timer         <= '0;
      end else begin
        case (state)
          IDLE: begin
            gain_dB_o     <= GAIN_INIT;
            set_gain_o    <= 1'b1;
            datapath_en_o <= 1'b1;
            state         <= APPLY;
          end
          APPLY: begin
            timer <= '0;
            state <= WAIT_HI;
          end
          WAIT_HI: begin
            if (gain_set_in_progress_i) begin
              timer <= '0;
              state <= WAIT_LO;
            end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
              timeout_o <= 1'b1;
              cnt       <= '0;
              state     <= SETTLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          WAIT_LO: begin
            if (!gain_set_in_progress_i) begin
              cnt   <= '0;
              state <= SETTLE;
            end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
              timeout_o <= 1'b1;
              cnt       <= '0;
              state     <= SETTLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          SETTLE: begin
            if (rssi_dB_valid_i) begin
              if (cnt == CNT_W'(SETTLE_SAMPLES - 1)) begin
                cnt   <= '0;
                acc   <= '0;
                state <= MEASURE;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          MEASURE: begin
            if (rssi_dB_valid_i) begin
              acc <= acc + ACC_W'(rssi_dB_i);
              if (cnt == CNT_W'(NAVG - 1)) begin
                cnt   <= '0;
                state <= DECIDE;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          DECIDE: begin
            acc <= '0;
            cnt <= '0;
            if (in_band) begin
              locked_o   <= 1'b1;
              at_limit_o <= 1'b0;
              state      <= MEASURE;
            end else begin
              locked_o   <= 1'b0;
              at_limit_o <= clamped;
              if (new_gain == gain_dB_o) begin
                state <= MEASURE;
              end else begin
                gain_dB_o  <= new_gain;
                set_gain_o <= 1'b1;
                state      <= APPLY;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_agc_controller.sv
// Self-checking bench for agc_controller. An AFE model answers each set
// strobe with a 3-cycle in-progress pulse. A reference model of the
// decision rule pushes every expected commanded gain into a scoreboard
// queue, and a monitor pops the queue on each set_gain_o pulse it sees.
module tb_agc_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_i = 1'b0;
  logic [15:0] rssi_dB_i = '0;
  logic        rssi_dB_valid_i = 1'b0;
  logic        gain_set_in_progress_i = 1'b0;
  logic [7:0]  gain_dB_o;
  logic        set_gain_o, datapath_en_o, locked_o, at_limit_o, timeout_o;

  int checks = 0;
  int errors = 0;

  bit afe_en = 1'b1;
  int exp_q[$];

  // reference model state
  int m_gain = 30;
  bit m_locked = 0;
  bit m_limit = 0;

  agc_controller dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .en_i                   (en_i),
    .rssi_dB_i              (rssi_dB_i),
    .rssi_dB_valid_i        (rssi_dB_valid_i),
    .gain_set_in_progress_i (gain_set_in_progress_i),
    .gain_dB_o              (gain_dB_o),
    .set_gain_o             (set_gain_o),
    .datapath_en_o          (datapath_en_o),
    .locked_o               (locked_o),
    .at_limit_o             (at_limit_o),
    .timeout_o              (timeout_o)
  );

  always #5 clk = ~clk;

  // AFE model: busy for 3 cycles, starting one cycle after each set strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (set_gain_o && afe_en) begin
        @(negedge clk);
        gain_set_in_progress_i = 1'b1;
        repeat (3) @(negedge clk);
        gain_set_in_progress_i = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every set pulse must match the next expected gain.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && set_gain_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_set gain got %0d, no set expected", gain_dB_o);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (gain_dB_o !== 8'(e)) begin
            errors++;
            $display("FAIL sb_gain got %0d exp %0d", gain_dB_o, e);
          end
        end
      end
    end
  end

  // Decision rule applied to a 16-sample sum.
  task automatic model_decide(input int sum, output bit changed);
    int avg, err, mag, d, n;
    avg = sum / 16;
    err = 'h3C00 - avg;
    mag = (err < 0) ? -err : err;
    changed = 0;
    if (mag <= 'h0300) begin
      m_locked = 1;
      m_limit  = 0;
    end else begin
      m_locked = 0;
      d = err >>> 8;
      if (d == 0) d = (err > 0) ? 1 : -1;
      if (d > 12) d = 12;
      if (d < -12) d = -12;
      n = m_gain + d;
      m_limit = 0;
      if (n < 0) begin n = 0; m_limit = 1; end
      if (n > 60) begin n = 60; m_limit = 1; end
      changed = (n != m_gain);
      m_gain = n;
    end
  endtask

  // Wait out the handshake, then feed 32 junk samples to be discarded.
  task automatic settle();
    repeat (8) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rssi_dB_i = 16'($urandom);
      rssi_dB_valid_i = 1'b1;
      @(negedge clk);
      rssi_dB_valid_i = 1'b0;
    end
  endtask

  // Feed one averaging window (base + i*step) back to back and check the
  // decision exactly 2 cycles after the last sample.
  task automatic run_window(input string name, input int base, input int step,
                            output bit changed);
    int sum = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rssi_dB_i = 16'(base + i * step);
      rssi_dB_valid_i = 1'b1;
      sum += base + i * step;
    end
    model_decide(sum, changed);
    if (changed) exp_q.push_back(m_gain);
    @(negedge clk);
    rssi_dB_valid_i = 1'b0;
    checks++;
    if (set_gain_o !== 1'b0) begin
      errors++;
      $display("FAIL %s early_set got %0b exp 0", name, set_gain_o);
    end
    @(negedge clk);
    checks++;
    if (set_gain_o !== changed) begin
      errors++;
      $display("FAIL %s set_latency got %0b exp %0b", name, set_gain_o, changed);
    end
    checks++;
    if (gain_dB_o !== 8'(m_gain)) begin
      errors++;
      $display("FAIL %s gain got %0d exp %0d", name, gain_dB_o, m_gain);
    end
    checks++;
    if (locked_o !== m_locked || at_limit_o !== m_limit) begin
      errors++;
      $display("FAIL %s locked/at_limit got %0b/%0b exp %0b/%0b", name,
               locked_o, at_limit_o, m_locked, m_limit);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (gain_dB_o !== 8'd30 || set_gain_o !== 1'b0 || datapath_en_o !== 1'b0 ||
        locked_o !== 1'b0 || at_limit_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got gain=%0d set=%0b dp=%0b lk=%0b lim=%0b to=%0b exp 30/0/0/0/0/0",
               gain_dB_o, set_gain_o, datapath_en_o, locked_o, at_limit_o, timeout_o);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (datapath_en_o !== 1'b0 || set_gain_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_disabled got dp=%0b set=%0b exp 0/0", datapath_en_o, set_gain_o);
    end
  endtask

  task automatic test_enable();
    bit ch;
    en_i = 1'b1;
    m_gain = 30;
    exp_q.push_back(30);
    @(negedge clk);
    checks++;
    if (set_gain_o !== 1'b1 || gain_dB_o !== 8'd30 || datapath_en_o !== 1'b1) begin
      errors++;
      $display("FAIL enable_apply got set=%0b gain=%0d dp=%0b exp 1/30/1",
               set_gain_o, gain_dB_o, datapath_en_o);
    end
    @(negedge clk);
    checks++;
    if (set_gain_o !== 1'b0) begin
      errors++;
      $display("FAIL enable_one_cycle got set=%0b exp 0", set_gain_o);
    end
    settle();
    // 61 dB sits inside the dead band. If the junk settle samples had been
    // counted, this window would not line up and the gain would move.
    run_window("lock", 'h3D00, 0, ch);
  endtask

  task automatic test_step_up();
    bit ch;
    run_window("step_up_40dB", 'h2800, 0, ch);
    settle();
    run_window("step_up_20dB", 'h1400, 0, ch);
    settle();
  endtask

  task automatic test_limit();
    bit ch;
    run_window("limit_hit", 'h1400, 0, ch);
    settle();
    run_window("limit_hold", 'h1400, 0, ch);
  endtask

  task automatic test_step_down();
    bit ch;
    run_window("step_down_80dB", 'h5000, 0, ch);
    settle();
    run_window("ramp_trunc", 'h3000, 'h11, ch);
    settle();
  endtask

  task automatic test_timeout();
    bit ch;
    afe_en = 1'b0;
    run_window("timeout_set", 'h4600, 0, ch);
    repeat (1020) @(negedge clk);
    checks++;
    if (timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got %0b exp 0", timeout_o);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flag got %0b exp 1", timeout_o);
    end
    // SETTLE has already been entered; counting picks up from here.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rssi_dB_i = 16'($urandom);
      rssi_dB_valid_i = 1'b1;
    end
    @(negedge clk);
    rssi_dB_valid_i = 1'b0;
    run_window("timeout_resume", 'h3C00, 0, ch);
    afe_en = 1'b1;
  endtask

  task automatic test_disable();
    bit ch;
    run_window("disable_set", 'h3000, 0, ch);
    @(negedge clk);
    @(negedge clk);
    en_i = 1'b0;  // the FSM is in WAIT_LO with the AFE busy
    @(negedge clk);
    checks++;
    if (datapath_en_o !== 1'b0 || set_gain_o !== 1'b0) begin
      errors++;
      $display("FAIL disable_idle got dp=%0b set=%0b exp 0/0", datapath_en_o, set_gain_o);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (gain_dB_o !== 8'(m_gain)) begin
      errors++;
      $display("FAIL disable_gain_hold got %0d exp %0d", gain_dB_o, m_gain);
    end
    en_i = 1'b1;
    m_gain = 30;
    exp_q.push_back(30);
    @(negedge clk);
    checks++;
    if (set_gain_o !== 1'b1 || gain_dB_o !== 8'd30 || datapath_en_o !== 1'b1) begin
      errors++;
      $display("FAIL reenable got set=%0b gain=%0d dp=%0b exp 1/30/1",
               set_gain_o, gain_dB_o, datapath_en_o);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rssi_dB_i = 16'h1400;
      rssi_dB_valid_i = 1'b1;
    end
    @(negedge clk);
    rssi_dB_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    en_i = 1'b0;
    #1;
    checks++;
    if (gain_dB_o !== 8'd30 || set_gain_o !== 1'b0 || datapath_en_o !== 1'b0 ||
        locked_o !== 1'b0 || at_limit_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got gain=%0d set=%0b dp=%0b lk=%0b lim=%0b to=%0b exp 30/0/0/0/0/0",
               gain_dB_o, set_gain_o, datapath_en_o, locked_o, at_limit_o, timeout_o);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending exp 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_step_up();
    test_limit();
    test_step_down();
    test_timeout();
    test_disable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
